// File: rtl/hazard3_ahbl_arb_2to1_if.sv
// rtl/hazard3_ahbl_arb_2to1_if.sv - AHB-Lite bus bundle used on every arbiter port
//
// Purpose: one AHB-Lite master/slave connection (address phase, write data,
// ready/response/read data).
// Modports:
//   master - drives haddr/hwrite/htrans/hsize/hburst/hprot/hmastlock/hwdata,
//            receives hready/hresp/hrdata
//   slave  - the mirror image
interface hazard3_ahbl_arb_2to1_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic [W_ADDR-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic              hmastlock;
    logic [W_DATA-1:0] hwdata;
    logic              hready;
    logic              hresp;
    logic [W_DATA-1:0] hrdata;

    modport master (
        output haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata,
        input  hready, hresp, hrdata
    );

    modport slave (
        input  haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata,
        output hready, hresp, hrdata
    );
endinterface

// File: rtl/hazard3_ahbl_arb_2to1.sv
// rtl/hazard3_ahbl_arb_2to1.sv - two-master to one-slave AHB-Lite arbiter
//
// Purpose: merges the load/store port (s0) and the instruction-fetch port (s1)
// onto one downstream AHB-Lite master port (m). A losing address phase is held
// in a per-port buffer and that port is stalled until the buffered transfer has
// been issued and its data phase completes.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   s0     - upstream load/store port (slave modport)
//   s1     - upstream fetch port (slave modport)
//   m      - downstream port (master modport)
// Configuration macro: HAZARD3_ARB_ROUND_ROBIN_EN
//   undefined - fixed priority, s0 wins every conflict
//   defined   - conflicts alternate via a last_winner register
module hazard3_ahbl_arb_2to1 #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hazard3_ahbl_arb_2to1_if.slave  s0,
    hazard3_ahbl_arb_2to1_if.slave  s1,
    hazard3_ahbl_arb_2to1_if.master m
);

    typedef struct packed {
        logic [W_ADDR-1:0] haddr;
        logic              hwrite;
        logic [2:0]        hsize;
        logic [2:0]        hburst;
        logic [3:0]        hprot;
        logic              hmastlock;
    } aph_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_S0   = 2'd1,
        OWN_S1   = 2'd2
    } owner_t;

    aph_t   buf0_q, buf0_d, buf1_q, buf1_d;
    logic   buf0_vld_q, buf0_vld_d, buf1_vld_q, buf1_vld_d;
    owner_t dph_owner_q, dph_owner_d;
    logic   locked_q, locked_d;
    logic   lock_port_q, lock_port_d;   // 0 = s0 holds the lock, 1 = s1

    aph_t   live0, live1, cand0_aph, cand1_aph, win_aph;
    logic   s0_rdy, s1_rdy, live_req0, live_req1, cand0, cand1;
    logic   win0, win1, grant_any;
    logic   unused_htrans;

    assign live0 = {s0.haddr, s0.hwrite, s0.hsize, s0.hburst, s0.hprot, s0.hmastlock};
    assign live1 = {s1.haddr, s1.hwrite, s1.hsize, s1.hburst, s1.hprot, s1.hmastlock};

    // A buffered port is stalled until its transfer is granted and becomes the
    // data-phase owner; the buffer clears at the grant, so buf_vld alone covers
    // both "buffered" and "buffer is the current downstream address phase".
    assign s0_rdy = (dph_owner_q == OWN_S0) ? m.hready : !buf0_vld_q;
    assign s1_rdy = (dph_owner_q == OWN_S1) ? m.hready : !buf1_vld_q;

    assign live_req0 = s0.htrans[1] && s0_rdy;
    assign live_req1 = s1.htrans[1] && s1_rdy;

    assign cand0     = buf0_vld_q || live_req0;
    assign cand1     = buf1_vld_q || live_req1;
    assign cand0_aph = buf0_vld_q ? buf0_q : live0;
    assign cand1_aph = buf1_vld_q ? buf1_q : live1;

`ifdef HAZARD3_ARB_ROUND_ROBIN_EN
    // 1 means s1 won the previous conflict, so s0 takes the next one.
    logic last_winner_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner_q <= 1'b1;
        end else if (m.hready && cand0 && cand1) begin
            last_winner_q <= win1;
        end
    end
`endif

    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (locked_q) begin
            // The locked port keeps the bus; the other port waits even if idle cycles pass.
            win0 = cand0 && !lock_port_q;
            win1 = cand1 && lock_port_q;
        end else if (cand0 && cand1) begin
`ifdef HAZARD3_ARB_ROUND_ROBIN_EN
            win0 = last_winner_q;
            win1 = !last_winner_q;
`else
            win0 = 1'b1;
`endif
        end else begin
            win0 = cand0;
            win1 = cand1;
        end
    end

    assign grant_any = win0 || win1;
    assign win_aph   = win1 ? cand1_aph : cand0_aph;

    assign m.htrans    = grant_any ? 2'b10 : 2'b00;
    assign m.haddr     = grant_any ? win_aph.haddr     : '0;
    assign m.hwrite    = grant_any ? win_aph.hwrite    : 1'b0;
    assign m.hsize     = grant_any ? win_aph.hsize     : 3'b000;
    assign m.hburst    = grant_any ? win_aph.hburst    : 3'b000;
    assign m.hprot     = grant_any ? win_aph.hprot     : 4'b0000;
    assign m.hmastlock = grant_any ? win_aph.hmastlock : 1'b0;

    assign m.hwdata = (dph_owner_q == OWN_S0) ? s0.hwdata :
                      (dph_owner_q == OWN_S1) ? s1.hwdata : '0;

    assign s0.hready = s0_rdy;
    assign s1.hready = s1_rdy;
    assign s0.hresp  = (dph_owner_q == OWN_S0) && m.hresp;
    assign s1.hresp  = (dph_owner_q == OWN_S1) && m.hresp;
    assign s0.hrdata = m.hrdata;
    assign s1.hrdata = m.hrdata;

    assign unused_htrans = s0.htrans[0] ^ s1.htrans[0];

    always_comb begin
        buf0_vld_d  = buf0_vld_q;
        buf1_vld_d  = buf1_vld_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        dph_owner_d = dph_owner_q;
        locked_d    = locked_q;
        lock_port_d = lock_port_q;

        if (m.hready) begin
            if (win0 && buf0_vld_q) buf0_vld_d = 1'b0;
            if (win1 && buf1_vld_q) buf1_vld_d = 1'b0;
            dph_owner_d = win0 ? OWN_S0 : (win1 ? OWN_S1 : OWN_NONE);
            if (grant_any) begin
                locked_d    = win_aph.hmastlock;
                lock_port_d = win1;
            end else if (locked_q) begin
                // Locked port went idle: the lock survives only if it keeps hmastlock high.
                locked_d = lock_port_q ? s1.hmastlock : s0.hmastlock;
            end
        end

        // A live request that is not issued this edge is parked. It can never
        // meet a valid buffer because the port's hready is low while buffered.
        if (live_req0 && !(win0 && m.hready)) begin
            buf0_vld_d = 1'b1;
            buf0_d     = live0;
        end
        if (live_req1 && !(win1 && m.hready)) begin
            buf1_vld_d = 1'b1;
            buf1_d     = live1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf0_vld_q  <= 1'b0;
            buf1_vld_q  <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            dph_owner_q <= OWN_NONE;
            locked_q    <= 1'b0;
            lock_port_q <= 1'b0;
        end else begin
            buf0_vld_q  <= buf0_vld_d;
            buf1_vld_q  <= buf1_vld_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            dph_owner_q <= dph_owner_d;
            locked_q    <= locked_d;
            lock_port_q <= lock_port_d;
        end
    end

endmodule
